// File: rtl/input_matrix_scanner_pkg.sv
// Shared constants and event layout for the keypad matrix scanner.
package input_matrix_scanner_pkg;

  localparam int ROWS_DEF = 4;
  localparam int COLS_DEF = 4;

  // Number of keys in the matrix.
  function automatic int nk_of(input int rows, input int cols);
    return rows * cols;
  endfunction

  // Width of a key index, row*COLS+col.
  function automatic int cw_of(input int rows, input int cols);
    return $clog2(rows * cols);
  endfunction

  // Event word is {press, code}: code in the low CW bits, press just above.
  function automatic int ev_w(input int cw);
    return cw + 1;
  endfunction

  localparam int NK_DEF = nk_of(ROWS_DEF, COLS_DEF);
  localparam int CW_DEF = cw_of(ROWS_DEF, COLS_DEF);

endpackage

// File: rtl/input_matrix_scanner_if.sv
// Pin and event-handshake bundle of the keypad scanner.
interface input_matrix_scanner_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4
);
  import input_matrix_scanner_pkg::*;

  localparam int NK = nk_of(ROWS, COLS);
  localparam int CW = cw_of(ROWS, COLS);

  logic [ROWS-1:0] H;
  logic [COLS-1:0] V;
  logic [CW-1:0]   code;
  logic            press;
  logic            valid;
  logic            ready;
  logic [NK-1:0]   held;
  logic            overflow;
  logic            ovf_clr;

  // Scanner side.
  modport master (
    output H, code, press, valid, held, overflow,
    input  V, ready, ovf_clr
  );

  // Board pins plus key encoder side.
  modport slave (
    input  H, code, press, valid, held, overflow,
    output V, ready, ovf_clr
  );
endinterface

// File: rtl/input_matrix_scanner_event_fifo.sv
// Show-ahead event FIFO with wrap-bit pointers and a drop flag for pushes lost to a full queue.
module input_event_fifo #(
  parameter int W     = 5,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full,
  output logic         drop
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [AW:0]             wr_q, wr_d, rd_q, rd_d;
  logic                    do_pop, do_push;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign rdata = mem_q[rd_q[AW-1:0]];

  // A full queue still takes a push when the head leaves in the same cycle.
  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    drop    = push & full & ~do_pop;
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (do_push) begin
      mem_d[wr_q[AW-1:0]] = wdata;
      wr_d                = wr_q + PTR_ONE;
    end
    if (do_pop) rd_d = rd_q + PTR_ONE;
  end

  // Storage and pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
    end
  end

endmodule

// File: rtl/input_matrix_scanner.sv
// Keypad matrix front end: row sequencer, column synchroniser, per-key
// frame-integrating debounce, lowest-index event arbiter and event FIFO.
module input_matrix_scanner
  import input_matrix_scanner_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int DEBOUNCE   = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input_matrix_scanner_if.master bus
);
  localparam int NK = nk_of(ROWS, COLS);
  localparam int CW = cw_of(ROWS, COLS);
  localparam int EW = ev_w(CW);
  localparam int RW = $clog2(ROWS);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(DEBOUNCE + 1);

  localparam logic [RW-1:0]   R_LAST = RW'(ROWS - 1);
  localparam logic [DW-1:0]   D_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0]   B_LAST = BW'(DEBOUNCE);
  localparam logic [ROWS-1:0] H_ONE  = ROWS'(1);

  logic [RW-1:0]             r_q, r_d;
  logic [DW-1:0]             d_q, d_d;
  logic [1:0][COLS-1:0]      vs_q, vs_d;
  logic [NK-1:0]             held_q, held_d;
  logic [NK-1:0][BW-1:0]     cnt_q, cnt_d;
  logic [NK-1:0]             pend_q, pend_d;
  logic                      ovf_q, ovf_d;

  logic                      strobe;
  logic [NK-1:0]             grant;
  logic                      push;
  logic [CW-1:0]             push_code;
  logic                      push_press;
  logic [EW-1:0]             rdata;
  logic                      fifo_empty, fifo_full, drop;

  // The last divider cycle both samples the settled row and advances to the next row.
  assign strobe = (d_q == D_LAST);

  // Row/divider stepping and the two-flop column synchroniser.
  always_comb begin
    d_d  = d_q + DW'(1);
    r_d  = r_q;
    vs_d = {vs_q[0], bus.V};
    if (strobe) begin
      d_d = '0;
      r_d = (r_q == R_LAST) ? '0 : r_q + RW'(1);
    end
  end

  // Debounce the keys of the driven row; a key flips after DEBOUNCE disagreeing samples.
  always_comb begin
    held_d = held_q;
    cnt_d  = cnt_q;
    pend_d = pend_q & ~grant;
    for (int k = 0; k < NK; k++) begin
      if (strobe && (int'(r_q) == k / COLS)) begin
        if (vs_q[1][k % COLS] == held_q[k]) begin
          cnt_d[k] = '0;
        end else if (cnt_q[k] + BW'(1) == B_LAST) begin
          held_d[k] = ~held_q[k];
          cnt_d[k]  = '0;
          pend_d[k] = 1'b1;
        end else begin
          cnt_d[k] = cnt_q[k] + BW'(1);
        end
      end
    end
  end

  // Grant the lowest-index pending key; its event carries the already-updated key state.
  always_comb begin
    grant      = '0;
    push       = 1'b0;
    push_code  = '0;
    push_press = 1'b0;
    for (int k = NK - 1; k >= 0; k--) begin
      if (pend_q[k]) begin
        grant      = '0;
        grant[k]   = 1'b1;
        push       = 1'b1;
        push_code  = CW'(k);
        push_press = held_q[k];
      end
    end
  end

  // A drop in the same cycle as a clear leaves the flag set.
  always_comb begin
    ovf_d = (ovf_q & ~bus.ovf_clr) | drop;
  end

  // All scanner state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q    <= '0;
      d_q    <= '0;
      vs_q   <= '0;
      held_q <= '0;
      cnt_q  <= '0;
      pend_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      r_q    <= r_d;
      d_q    <= d_d;
      vs_q   <= vs_d;
      held_q <= held_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  input_event_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({push_press, push_code}),
    .pop   (bus.valid & bus.ready),
    .rdata (rdata),
    .empty (fifo_empty),
    .full  (fifo_full),
    .drop  (drop)
  );

  assign bus.H        = H_ONE << r_q;
  assign bus.code     = rdata[CW-1:0];
  assign bus.press    = rdata[CW];
  assign bus.valid    = ~fifo_empty;
  assign bus.held     = held_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_input_matrix_scanner.sv
// Bench for input_matrix_scanner: directed scenarios plus a randomized run,
// all checked against a queue-based model of scan frames and the event queue.
module tb_input_matrix_scanner;
  localparam int ROWS       = 4;
  localparam int COLS       = 4;
  localparam int SCAN_DIV   = 8;
  localparam int DEBOUNCE   = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int NK         = ROWS * COLS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NK-1:0] keys = '0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  input_matrix_scanner_if #(.ROWS(ROWS), .COLS(COLS)) bus();

  input_matrix_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE(DEBOUNCE), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Key matrix: a closed key connects its row line to its column line.
  always_comb begin
    bus.V = '0;
    for (int r = 0; r < ROWS; r++)
      if (bus.H[r]) bus.V = bus.V | keys[r*COLS +: COLS];
  end

  // Reference model: cycle count since reset gives row and divider phase;
  // each row's columns are seen two cycles before its sampling point.
  int            mt;
  int            m_cnt [NK];
  logic [NK-1:0] m_held;
  logic [COLS-1:0] snap;
  int            pend [$];
  int            mq [$];
  logic          m_ovf;
  int            md, mrow, mk, me;
  bit            mdrop;

  always @(posedge clk) begin
    if (rst) begin
      mt = 0; m_held = '0; snap = '0; m_ovf = 1'b0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
      pend.delete(); mq.delete();
    end else begin
      md = mt % SCAN_DIV;
      mrow = (mt / SCAN_DIV) % ROWS;
      mdrop = 0;
      if (bus.ready && mq.size() > 0) void'(mq.pop_front());
      if (pend.size() > 0) begin
        me = pend.pop_front();
        if (mq.size() < FIFO_DEPTH) mq.push_back(me);
        else mdrop = 1;
      end
      m_ovf = (m_ovf && !bus.ovf_clr) || mdrop;
      if (md == SCAN_DIV - 1) begin
        for (int c = 0; c < COLS; c++) begin
          mk = mrow * COLS + c;
          if (snap[c] == m_held[mk]) m_cnt[mk] = 0;
          else begin
            m_cnt[mk]++;
            if (m_cnt[mk] == DEBOUNCE) begin
              m_held[mk] = ~m_held[mk];
              m_cnt[mk] = 0;
              pend.push_back(mk + (m_held[mk] ? NK : 0));
            end
          end
        end
      end
      if (md == SCAN_DIV - 3) snap = keys[mrow*COLS +: COLS];
      mt++;
    end
  end

  // Returns on the first negedge showing valid; lat = -1 if none within budget.
  task automatic wait_event(input int budget, output int lat, output logic [4:0] ev);
    lat = -1;
    ev = '0;
    for (int i = 1; i <= budget && lat < 0; i++) begin
      @(negedge clk);
      if (bus.valid === 1'b1) begin
        lat = i;
        ev = {bus.press, bus.code};
      end
    end
  endtask

  // Leaves the bench at the negedge inside the first cycle after reset.
  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [ROWS-1:0] exp_h;
    keys = '0; bus.ready = 1'b1; bus.ovf_clr = 1'b0;
    do_reset();
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", bus.valid); end
    checks++; if (bus.held !== '0) begin errors++; $display("FAIL reset_held got=%h want=0", bus.held); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b want=0", bus.overflow); end
    checks++; if ({bus.press, bus.code} !== 5'd0) begin errors++; $display("FAIL reset_event got=%h want=0", {bus.press, bus.code}); end
    for (int i = 0; i <= 4 * SCAN_DIV; i++) begin
      exp_h = ROWS'(1) << ((i / SCAN_DIV) % ROWS);
      checks++; if (bus.H !== exp_h) begin errors++; $display("FAIL reset_rowseq cyc=%0d got=%b want=%b", i, bus.H, exp_h); end
      checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_idle cyc=%0d valid=%b want=0", i, bus.valid); end
      @(negedge clk);
    end
  endtask

  task automatic test_make_break();
    int lat; logic [4:0] ev;
    keys = '0; bus.ready = 1'b1;
    do_reset();
    keys[10] = 1'b1;
    wait_event(200, lat, ev);
    checks++; if (lat != 89) begin errors++; $display("FAIL make_latency got=%0d want=89", lat); end
    checks++; if (ev !== 5'b1_1010) begin errors++; $display("FAIL make_event got=%h want=%h", ev, 5'b1_1010); end
    checks++; if (bus.held !== 16'h0400) begin errors++; $display("FAIL make_held got=%h want=0400", bus.held); end
    wait_event(64, lat, ev);
    checks++; if (lat != -1) begin errors++; $display("FAIL make_single extra event=%h at %0d", ev, lat); end
    keys[10] = 1'b0;
    wait_event(200, lat, ev);
    checks++; if (lat < 0 || ev !== 5'b0_1010) begin errors++; $display("FAIL break_event got=%h lat=%0d want=%h", ev, lat, 5'b0_1010); end
    checks++; if (bus.held !== '0) begin errors++; $display("FAIL break_held got=%h want=0", bus.held); end
  endtask

  task automatic test_bounce();
    int lat; logic [4:0] ev;
    keys = '0; bus.ready = 1'b1;
    do_reset();
    keys[5] = 1'b1;
    wait_event(2 * ROWS * SCAN_DIV, lat, ev);
    keys[5] = 1'b0;
    checks++; if (lat != -1) begin errors++; $display("FAIL bounce_during got=%h at %0d want none", ev, lat); end
    wait_event(128, lat, ev);
    checks++; if (lat != -1) begin errors++; $display("FAIL bounce_after got=%h at %0d want none", ev, lat); end
    checks++; if (bus.held !== '0) begin errors++; $display("FAIL bounce_held got=%h want=0", bus.held); end
  endtask

  task automatic test_multi();
    int lat; logic [4:0] ev;
    keys = '0; bus.ready = 1'b1;
    do_reset();
    keys[4] = 1'b1; keys[6] = 1'b1; keys[7] = 1'b1;
    wait_event(200, lat, ev);
    checks++; if (ev !== 5'b1_0100) begin errors++; $display("FAIL multi_first got=%h want=%h", ev, 5'b1_0100); end
    @(negedge clk);
    checks++; if (bus.valid !== 1'b1 || {bus.press, bus.code} !== 5'b1_0110) begin errors++; $display("FAIL multi_second valid=%b got=%h want=%h", bus.valid, {bus.press, bus.code}, 5'b1_0110); end
    @(negedge clk);
    checks++; if (bus.valid !== 1'b1 || {bus.press, bus.code} !== 5'b1_0111) begin errors++; $display("FAIL multi_third valid=%b got=%h want=%h", bus.valid, {bus.press, bus.code}, 5'b1_0111); end
    @(negedge clk);
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL multi_end valid=%b want=0", bus.valid); end
    checks++; if (bus.held !== 16'h00D0) begin errors++; $display("FAIL multi_held got=%h want=00d0", bus.held); end
  endtask

  task automatic test_overflow();
    keys = '0; bus.ready = 1'b0;
    do_reset();
    keys[3:0] = 4'hF; keys[8] = 1'b1;
    repeat (140) @(negedge clk);
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b want=1", bus.overflow); end
    checks++; if (bus.held !== 16'h010F) begin errors++; $display("FAIL ovf_held got=%h want=010f", bus.held); end
    bus.ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      checks++; if (bus.valid !== 1'b1 || {bus.press, bus.code} !== 5'(16 + j)) begin errors++; $display("FAIL ovf_drain%0d valid=%b got=%h want=%h", j, bus.valid, {bus.press, bus.code}, 5'(16 + j)); end
      @(negedge clk);
    end
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL ovf_empty valid=%b want=0", bus.valid); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b want=1", bus.overflow); end
    bus.ovf_clr = 1'b1;
    @(negedge clk);
    bus.ovf_clr = 1'b0;
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b want=0", bus.overflow); end
  endtask

  task automatic test_reset_mid_drain();
    int lat; logic [4:0] ev;
    keys = '0; bus.ready = 1'b0;
    do_reset();
    keys[10] = 1'b1; keys[11] = 1'b1;
    repeat (100) @(negedge clk);
    checks++; if (bus.valid !== 1'b1 || bus.held !== 16'h0C00) begin errors++; $display("FAIL midrst_pre valid=%b held=%h want 1/0c00", bus.valid, bus.held); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b want=0", bus.valid); end
    checks++; if (bus.held !== '0) begin errors++; $display("FAIL midrst_held got=%h want=0", bus.held); end
    checks++; if (bus.H !== 4'b0001) begin errors++; $display("FAIL midrst_H got=%b want=0001", bus.H); end
    rst = 1'b0; bus.ready = 1'b1;
    wait_event(200, lat, ev);
    checks++; if (lat != 89 || ev !== 5'b1_1010) begin errors++; $display("FAIL midrst_redetect lat=%0d ev=%h want 89/%h", lat, ev, 5'b1_1010); end
  endtask

  task automatic test_random();
    int kk;
    logic [ROWS-1:0] exp_h;
    keys = '0; bus.ready = 1'b1; bus.ovf_clr = 1'b0;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      exp_h = ROWS'(1) << ((mt / SCAN_DIV) % ROWS);
      checks++; if (bus.valid !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b want=%b", i, bus.valid, mq.size() != 0); end
      if (bus.valid === 1'b1 && mq.size() != 0) begin
        checks++; if ({bus.press, bus.code} !== 5'(mq[0])) begin errors++; $display("FAIL rnd_event cyc=%0d got=%h want=%h", i, {bus.press, bus.code}, 5'(mq[0])); end
      end
      checks++; if (bus.held !== m_held) begin errors++; $display("FAIL rnd_held cyc=%0d got=%h want=%h", i, bus.held, m_held); end
      checks++; if (bus.overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf cyc=%0d got=%b want=%b", i, bus.overflow, m_ovf); end
      checks++; if (bus.H !== exp_h) begin errors++; $display("FAIL rnd_H cyc=%0d got=%b want=%b", i, bus.H, exp_h); end
      if ($urandom_range(0, 24) == 0) begin
        kk = $urandom_range(0, NK - 1);
        keys[kk] = ~keys[kk];
      end
      if (i >= 1500 && i < 2500) bus.ready = ($urandom_range(0, 19) == 0);
      else bus.ready = ($urandom_range(0, 3) != 0);
      bus.ovf_clr = ($urandom_range(0, 99) == 0);
    end
    bus.ovf_clr = 1'b0;
  endtask

  initial begin
    bus.ready = 1'b1;
    bus.ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_make_break();
    test_bounce();
    test_multi();
    test_overflow();
    test_reset_mid_drain();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
